// File: rtl/dvs_fifo_bus_scheduler.sv
// dvs_fifo_bus_scheduler
//   Registered, mutually exclusive arbiter for the shared FIFO event-queue bus.
//   The AER-side writer and the RAVENS-side reader request the bus. The arbiter
//   grants only an owner that can make progress: it does not grant a write while
//   the FIFO is full or a read while it is empty. Each tenure is bounded. One idle
//   turnaround cycle separates any two owners. A reader that stays eligible but
//   ungranted for too long gets forced priority, and that cuts a writer tenure short.
module dvs_fifo_bus_scheduler #(
  parameter int unsigned MAX_HOLD_CYCLES = 8,
  parameter int unsigned RD_STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic fifo_full,
  input  logic fifo_empty,
  output logic grant_wr,
  output logic grant_rd,
  output logic preempt,
  output logic starve_sat
);

  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD_CYCLES + 1);
  localparam int unsigned STARVE_W = $clog2(RD_STARVE_LIMIT + 1);

  // Value of hold_cnt during the last cycle a tenure may run.
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(MAX_HOLD_CYCLES - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(RD_STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GNT_WR,
    S_GNT_RD,
    S_TURN
  } state_e;

  typedef enum logic {
    OWN_WR,
    OWN_RD
  } owner_e;

  state_e               state_q, state_d;
  owner_e               last_owner_q, last_owner_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic                 grant_wr_q, grant_rd_q;
  logic                 preempt_q, preempt_d;
  logic                 starve_sat_q;

  logic wr_ok;
  logic rd_ok;
  logic hold_left;
  logic enter_wr;
  logic enter_rd;

  // An owner is eligible only if the FIFO can accept its transfer.
  assign wr_ok     = req_wr & ~fifo_full;
  assign rd_ok     = req_rd & ~fifo_empty;
  assign hold_left = (hold_cnt_q < HOLD_LAST);
  assign enter_wr  = (state_d == S_GNT_WR) && (state_q != S_GNT_WR);
  assign enter_rd  = (state_d == S_GNT_RD) && (state_q != S_GNT_RD);

  // Arbitration used in IDLE and TURN. A starved reader wins first. A tie then
  // goes to the side that did not own the bus last.
  function automatic state_e decide(input logic   sat,
                                    input logic   wr,
                                    input logic   rd,
                                    input owner_e last);
    if (sat && rd)     return S_GNT_RD;
    else if (wr && rd) return (last == OWN_WR) ? S_GNT_RD : S_GNT_WR;
    else if (wr)       return S_GNT_WR;
    else if (rd)       return S_GNT_RD;
    else               return S_IDLE;
  endfunction

  // Next-state logic: hold the tenure while the owner is eligible and has time left,
  // otherwise hand over through TURN.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    preempt_d    = 1'b0;
    case (state_q)
      S_IDLE, S_TURN: begin
        state_d = decide(starve_sat_q, wr_ok, rd_ok, last_owner_q);
      end
      S_GNT_WR: begin
        if (!(wr_ok && hold_left && !starve_sat_q)) begin
          state_d      = S_TURN;
          last_owner_d = OWN_WR;
          // Flag only exits that reader starvation alone forces.
          preempt_d    = wr_ok && hold_left && starve_sat_q;
        end
      end
      S_GNT_RD: begin
        if (!(rd_ok && hold_left)) begin
          state_d      = S_TURN;
          last_owner_d = OWN_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tenure and starvation counters: the tenure counter restarts at each grant,
  // and the starvation counter counts reader wait cycles.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if ((state_q == S_GNT_WR) || (state_q == S_GNT_RD)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    if (enter_wr || enter_rd) begin
      hold_cnt_d = '0;
    end

    starve_cnt_d = starve_cnt_q;
    if (rd_ok && (state_q != S_GNT_RD) && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
    if (enter_rd) begin
      starve_cnt_d = '0;
    end
  end

  // State, counters and registered outputs. Reset removes any grant at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_owner_q <= OWN_RD;
      hold_cnt_q   <= '0;
      starve_cnt_q <= '0;
      grant_wr_q   <= 1'b0;
      grant_rd_q   <= 1'b0;
      preempt_q    <= 1'b0;
      starve_sat_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the values
      // from before this edge and the order of the statements does not matter.
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      grant_wr_q   <= (state_d == S_GNT_WR);
      grant_rd_q   <= (state_d == S_GNT_RD);
      preempt_q    <= preempt_d;
      starve_sat_q <= (starve_cnt_d == STARVE_MAX);
    end
  end

  assign grant_wr   = grant_wr_q;
  assign grant_rd   = grant_rd_q;
  assign preempt    = preempt_q;
  assign starve_sat = starve_sat_q;

endmodule

// File: tb/tb_dvs_fifo_bus_scheduler.sv
// Directed testbench for dvs_fifo_bus_scheduler. dut_a uses the default parameters.
// dut_b has a long tenure (32) so that reader starvation can preempt the writer.
module tb_dvs_fifo_bus_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic req_wr, req_rd, fifo_full, fifo_empty;
  logic a_gwr, a_grd, a_pre, a_sat;
  logic b_gwr, b_grd, b_pre, b_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dvs_fifo_bus_scheduler dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_wr     (req_wr),
    .req_rd     (req_rd),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .grant_wr   (a_gwr),
    .grant_rd   (a_grd),
    .preempt    (a_pre),
    .starve_sat (a_sat)
  );

  dvs_fifo_bus_scheduler #(
    .MAX_HOLD_CYCLES (32),
    .RD_STARVE_LIMIT (16)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_wr     (req_wr),
    .req_rd     (req_rd),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .grant_wr   (b_gwr),
    .grant_rd   (b_grd),
    .preempt    (b_pre),
    .starve_sat (b_sat)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock edge. Outputs are sampled 1 time unit later, and new inputs are
  // applied there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_in(input logic w, input logic r, input logic f, input logic e);
    req_wr     = w;
    req_rd     = r;
    fifo_full  = f;
    fifo_empty = e;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #3;

    // Reset state
    check("rst_gwr", a_gwr, 0);
    check("rst_grd", a_grd, 0);
    check("rst_pre", a_pre, 0);
    check("rst_sat", a_sat, 0);

    // 1: Writer alone. Expect 8 granted cycles, then 1 TURN cycle, repeating.
    set_in(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("t1_gwr_%0d", k), a_gwr, ((k % 9) != 0) ? 1 : 0);
      check($sformatf("t1_grd_%0d", k), a_grd, 0);
    end
    // The writer drops its request. The grant goes low on the next cycle.
    // At this point k=20 and 20%9=2, so the writer holds a grant.
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("t1_drop_gwr", a_gwr, 0);
    tick();
    check("t1_idle_gwr", a_gwr, 0);

    // 2: Both sides eligible. Expect WR x8, idle, RD x8, idle, alternating.
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      int p;
      p = (k - 1) % 18;
      tick();
      check($sformatf("t2_gwr_%0d", k), a_gwr, (p <= 7) ? 1 : 0);
      check($sformatf("t2_grd_%0d", k), a_grd, (p >= 9 && p <= 16) ? 1 : 0);
      check($sformatf("t2_excl_%0d", k), a_gwr & a_grd, 0);
      check($sformatf("t2_pre_%0d", k), a_pre, 0);
    end

    // 3: Long tenure (dut_b). The starvation counter saturates and the writer is preempted.
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("t3_gwr_%0d", k), b_gwr, (k <= 16) ? 1 : 0);
      check($sformatf("t3_grd_%0d", k), b_grd, (k == 18) ? 1 : 0);
      check($sformatf("t3_pre_%0d", k), b_pre, (k == 17) ? 1 : 0);
      check($sformatf("t3_sat_%0d", k), b_sat, (k == 16 || k == 17) ? 1 : 0);
    end

    // 4: FIFO full arrives in cycle 3 of a write tenure.
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    tick(); check("t4_c1_gwr", a_gwr, 1);
    tick(); check("t4_c2_gwr", a_gwr, 1);
    tick(); check("t4_c3_gwr", a_gwr, 1);
    fifo_full = 1'b1;
    tick(); check("t4_c4_gwr", a_gwr, 0);
    check("t4_c4_grd", a_grd, 0);
    tick(); check("t4_c5_grd", a_grd, 1);
    check("t4_c5_gwr", a_gwr, 0);

    // 5: Empty FIFO with only the reader requesting. No grant, and no starvation is counted.
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if ((k % 10) == 0) begin
        check($sformatf("t5_grd_%0d", k), a_grd, 0);
        check($sformatf("t5_sat_%0d", k), a_sat, 0);
      end
    end
    // Both flags set. Neither side is granted.
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t5b_gwr_%0d", k), a_gwr, 0);
      check($sformatf("t5b_grd_%0d", k), a_grd, 0);
    end

    // 6: Reset pulsed in the middle of a read tenure. On release, a tie goes to the writer.
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    tick(); check("t6_grd_1", a_grd, 1);
    tick(); check("t6_grd_2", a_grd, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_grd", a_grd, 0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_tie_gwr", a_gwr, 1);
    check("t6_tie_grd", a_grd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
